frame_scale_engine: RTL and testbench

//  Parametrised framebuffer scaling engine. Generalises the zoom address

---
 rtl/frame_scale_engine.sv | 219 +++++++++++++++++++++
 tb/tb_frame_scale_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scale_engine.sv
// Framebuffer scaling engine: copy, nearest-neighbour zoom-in, decimation
// zoom-out and block-average zoom-out between two frames of one RAM.
module frame_scale_engine #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int ADDR_W   = 17,
    parameter int PIX_W    = 8,
    parameter int RD_LAT   = 2,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 76800
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [1:0]        zoom,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [1:0] MODE_COPY  = 2'd0;
    localparam logic [1:0] MODE_NN    = 2'd1;
    localparam logic [1:0] MODE_DECIM = 2'd2;
    localparam logic [1:0] MODE_AVG   = 2'd3;

    localparam int MAXD  = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW    = $clog2(MAXD + 1);
    localparam int ACC_W = PIX_W + 4;

    localparam logic [31:0] W32     = IMG_W;
    localparam logic [31:0] H32     = IMG_H;
    localparam logic [31:0] SRC_B32 = SRC_BASE;
    localparam logic [31:0] DST_B32 = DST_BASE;
    localparam logic [1:0]  WAIT_END = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]        mode_q, zoom_q;
    logic [CW-1:0]     ix, iy;
    logic [1:0]        tx, ty;
    logic [1:0]        wait_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              error_q;

    logic [CW-1:0]     out_w, out_h;
    logic [1:0]        f_last;
    logic              cmd_ok, wait_last, last_tap, last_col, last_row, first_tap;
    logic [31:0]       ox, oy, sx, sy, dx, dy;
    logic [ADDR_W-1:0] rd_calc, wr_calc;
    logic [PIX_W-1:0]  pix_out;

    // Block average: divide the tap sum by F*F (shift by 2*zoom), truncating.
    function automatic logic [PIX_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum,
                                                   input logic [1:0]       zq);
        logic [ACC_W-1:0] sh;
        sh = sum >> {zq, 1'b0};
        return sh[PIX_W-1:0];
    endfunction

    assign cmd_ok    = (mode == MODE_COPY) || (zoom == 2'd1) || (zoom == 2'd2);
    assign wait_last = (wait_cnt == WAIT_END);
    assign first_tap = (tx == 2'd0) && (ty == 2'd0);
    assign last_tap  = (mode_q != MODE_AVG) || ((tx == f_last) && (ty == f_last));
    assign last_col  = (ix == out_w - CW'(1));
    assign last_row  = (iy == out_h - CW'(1));

    // Output extent, window offsets and source/destination coordinates.
    always_comb begin
        f_last = 2'((32'd1 << zoom_q) - 32'd1);
        ox     = (W32 - (W32 >> zoom_q)) >> 1;
        oy     = (H32 - (H32 >> zoom_q)) >> 1;
        out_w  = CW'(IMG_W);
        out_h  = CW'(IMG_H);
        sx     = 32'(ix);
        sy     = 32'(iy);
        dx     = 32'(ix);
        dy     = 32'(iy);
        case (mode_q)
            MODE_NN: begin
                sx = ox + (32'(ix) >> zoom_q);
                sy = oy + (32'(iy) >> zoom_q);
            end
            MODE_DECIM: begin
                out_w = CW'(W32 >> zoom_q);
                out_h = CW'(H32 >> zoom_q);
                sx    = 32'(ix) << zoom_q;
                sy    = 32'(iy) << zoom_q;
                dx    = ox + 32'(ix);
                dy    = oy + 32'(iy);
            end
            MODE_AVG: begin
                out_w = CW'(W32 >> zoom_q);
                out_h = CW'(H32 >> zoom_q);
                sx    = (32'(ix) << zoom_q) + 32'(tx);
                sy    = (32'(iy) << zoom_q) + 32'(ty);
                dx    = ox + 32'(ix);
                dy    = oy + 32'(iy);
            end
            default: begin
            end
        endcase
        rd_calc = ADDR_W'(SRC_B32 + sy * W32 + sx);
        wr_calc = ADDR_W'(DST_B32 + dy * W32 + dx);
        pix_out = (mode_q == MODE_AVG) ? avg_trunc(acc, zoom_q) : acc[PIX_W-1:0];
    end

    assign busy    = (state == S_RD_ISSUE) || (state == S_RD_WAIT) || (state == S_WR);
    assign done    = (state == S_DONE);
    assign error   = error_q;
    assign wr_en   = (state == S_WR);
    assign wr_addr = wr_en ? wr_calc : '0;
    assign wr_data = wr_en ? pix_out : '0;
    assign rd_addr = (state == S_RD_ISSUE) ? rd_calc : rd_addr_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state: read/wait per tap, one write per output pixel; abort wins while busy.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (start && cmd_ok) state_nx = S_RD_ISSUE;
            S_RD_ISSUE: state_nx = S_RD_WAIT;
            S_RD_WAIT:  if (wait_last) state_nx = last_tap ? S_WR : S_RD_ISSUE;
            S_WR:       state_nx = (last_col && last_row) ? S_DONE : S_RD_ISSUE;
            S_DONE:     state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
        if (abort && busy) state_nx = S_IDLE;
    end

    // Command latch, pixel/tap/wait counters, held read address and error pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_COPY;
            zoom_q    <= 2'd0;
            ix        <= '0;
            iy        <= '0;
            tx        <= 2'd0;
            ty        <= 2'd0;
            wait_cnt  <= 2'd0;
            rd_addr_q <= '0;
            error_q   <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cmd_ok) begin
                            mode_q   <= mode;
                            zoom_q   <= zoom;
                            ix       <= '0;
                            iy       <= '0;
                            tx       <= 2'd0;
                            ty       <= 2'd0;
                            wait_cnt <= 2'd0;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    rd_addr_q <= rd_calc;
                    wait_cnt  <= 2'd0;
                end
                S_RD_WAIT: begin
                    if (!wait_last) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end else if (last_tap) begin
                        tx <= 2'd0;
                        ty <= 2'd0;
                    end else if (tx == f_last) begin
                        tx <= 2'd0;
                        ty <= ty + 2'd1;
                    end else begin
                        tx <= tx + 2'd1;
                    end
                end
                S_WR: begin
                    if (last_col) begin
                        ix <= '0;
                        iy <= iy + CW'(1);
                    end else begin
                        ix <= ix + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tap accumulator: restarts on the first tap of each output block.
    always_ff @(posedge clock) begin
        if (state == S_RD_WAIT && wait_last) begin
            acc <= first_tap ? ACC_W'(rd_data) : acc + ACC_W'(rd_data);
        end
    end

endmodule

// File: tb/tb_frame_scale_engine.sv
// Scoreboard bench for frame_scale_engine on an 8x4 frame with a latency-2 RAM.
module tb_frame_scale_engine;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int AW  = 7;
    localparam int PW  = 8;
    localparam int LAT = 2;
    localparam int SB  = 0;
    localparam int DB  = 32;

    logic          clock = 1'b0;
    logic          reset, start, abort;
    logic [1:0]    mode, zoom;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [PW-1:0] rd_data, wr_data;
    logic          wr_en, busy, done, error;

    typedef struct {
        int addr;
        int data;
        int gap;
    } exp_t;

    exp_t     sb[$];
    exp_t     model_q[$];
    int       cur_per;
    int       n_cmp = 0;
    int       n_bad = 0;
    int       cyc   = 0;
    logic [PW-1:0] mem  [0:127];
    logic [PW-1:0] pipe [0:LAT-1];

    frame_scale_engine #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW),
        .RD_LAT(LAT), .SRC_BASE(SB), .DST_BASE(DB)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .zoom(zoom),
        .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM read port with LAT cycles of latency.
    always @(posedge clock) begin
        pipe[0] <= mem[rd_addr];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rd_data = pipe[LAT-1];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 128; i++) mem[i] = PW'($urandom);
    endtask

    // Reference: walk the destination frame row-major and decide each pixel.
    task automatic build_model(input int md, input int z);
        int f, ox, oy, per, v, sum;
        bit wr;
        model_q.delete();
        f   = (md == 0) ? 1 : (1 << z);
        ox  = (W - W / f) / 2;
        oy  = (H - H / f) / 2;
        per = (1 + LAT) * ((md == 3) ? f * f : 1) + 1;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                wr = 1'b1;
                v  = 0;
                if (md == 0) begin
                    v = int'(mem[SB + y * W + x]);
                end else if (md == 1) begin
                    v = int'(mem[SB + (oy + y / f) * W + ox + x / f]);
                end else begin
                    wr = (x >= ox) && (x < ox + W / f) && (y >= oy) && (y < oy + H / f);
                    if (wr) begin
                        if (md == 2) begin
                            v = int'(mem[SB + (y - oy) * f * W + (x - ox) * f]);
                        end else begin
                            sum = 0;
                            for (int b = 0; b < f; b++)
                                for (int a = 0; a < f; a++)
                                    sum += int'(mem[SB + ((y - oy) * f + b) * W + (x - ox) * f + a]);
                            v = sum / (f * f);
                        end
                    end
                end
                if (wr) model_q.push_back('{DB + y * W + x, v, (model_q.size() == 0) ? 0 : per});
            end
        end
        cur_per = per;
    endtask

    // Monitor: every write must match the head of the scoreboard.
    task automatic monitor();
        int   last_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (wr_en === 1'b1) begin
                check("wr_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("wr_addr", int'(wr_addr), e.addr);
                    check("wr_data", int'(wr_data), e.data);
                    if (e.gap > 0) check("wr_gap", cyc - last_cyc, e.gap);
                end
                last_cyc = cyc;
            end
        end
    endtask

    // Issue one command; optionally poke start while busy or abort after N writes.
    task automatic run_cmd(input int md, input int z, input int abort_after, input bit poke);
        int n, k, nw, bound, dcnt;
        bit seen_done, seen_err;
        build_model(md, z);
        n = model_q.size();
        for (int i = 0; i < n; i++)
            if (abort_after < 0 || i < abort_after) sb.push_back(model_q[i]);
        @(negedge clock);
        start = 1'b1; mode = 2'(md); zoom = 2'(z);
        @(negedge clock);
        start = 1'b0; mode = 2'($urandom); zoom = 2'($urandom);
        check("busy_after_start", int'(busy), 1);
        k = 0; nw = 0; seen_done = 0; seen_err = 0;
        bound = n * cur_per + 20;
        while (k < bound) begin
            @(negedge clock);
            k++;
            if (poke && k == 7) begin start = 1'b1; mode = 2'd1; zoom = 2'd0; end
            if (k == 8) start = 1'b0;
            if (error) seen_err = 1;
            if (wr_en) nw++;
            if (abort_after >= 0 && wr_en && nw == abort_after) begin
                abort = 1'b1;
                @(negedge clock);
                abort = 1'b0;
                check("abort_busy", int'(busy), 0);
                check("abort_done", int'(done), 0);
                dcnt = 0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clock);
                    if (done || busy) dcnt++;
                end
                check("abort_quiet", dcnt, 0);
                break;
            end
            if (done) begin
                check("done_cycle", k, n * cur_per);
                check("done_busy", int'(busy), 0);
                seen_done = 1;
                break;
            end
        end
        start = 1'b0;
        if (abort_after < 0) begin
            check("done_seen", int'(seen_done), 1);
            @(negedge clock);
            check("done_pulse", int'(done), 0);
        end
        if (poke) check("start_ignored_err", int'(seen_err), 0);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic reject(input int md, input int z);
        int r0;
        r0 = int'(rd_addr);
        @(negedge clock);
        start = 1'b1; mode = 2'(md); zoom = 2'(z);
        @(negedge clock);
        start = 1'b0;
        check("reject_error", int'(error), 1);
        check("reject_busy", int'(busy), 0);
        @(negedge clock);
        check("reject_error_pulse", int'(error), 0);
        check("reject_idle", int'(busy), 0);
        check("reject_no_read", int'(rd_addr), r0);
    endtask

    initial begin
        int md, z;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; zoom = 2'd0;
        fill_mem();
        fork
            monitor();
        join_none
        repeat (3) @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_busy", int'(busy), 0);

        // abort while idle does nothing
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("idle_abort_busy", int'(busy), 0);

        // copy (zoom ignored, even an otherwise invalid value)
        run_cmd(0, 3, -1, 1'b0);
        // nearest-neighbour zoom-in x2
        fill_mem();
        run_cmd(1, 1, -1, 1'b1);
        // block average x2 with a known first block: (10+20+30+41)/4 = 25
        fill_mem();
        mem[0] = 8'd10; mem[1] = 8'd20; mem[8] = 8'd30; mem[9] = 8'd41;
        run_cmd(3, 1, -1, 1'b0);
        // decimation x4
        fill_mem();
        run_cmd(2, 2, -1, 1'b1);

        // rejected commands
        reject(1, 0);
        reject(3, 3);
        reject(2, 0);

        // randomized commands
        for (int t = 0; t < 10; t++) begin
            fill_mem();
            md = $urandom_range(0, 3);
            z  = $urandom_range(1, 2);
            run_cmd(md, z, -1, 1'($urandom));
        end

        // abort right on the 5th write of a copy
        fill_mem();
        run_cmd(0, 1, 5, 1'b0);
        // the engine still runs normally afterwards
        run_cmd(3, 2, -1, 1'b0);

        // asynchronous reset in the middle of an average, during a write
        fill_mem();
        build_model(3, 2);
        foreach (model_q[i]) sb.push_back(model_q[i]);
        @(negedge clock);
        start = 1'b1; mode = 2'd3; zoom = 2'd2;
        @(negedge clock);
        start = 1'b0;
        begin
            int k;
            k = 0;
            while (!(wr_en === 1'b1) && k < 200) begin
                @(negedge clock);
                k++;
            end
            check("reset_test_reached_wr", int'(wr_en), 1);
        end
        #1 reset = 1'b1;
        #1;
        check("arst_wr_en", int'(wr_en), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_rd_addr", int'(rd_addr), 0);
        check("arst_wr_addr", int'(wr_addr), 0);
        check("arst_wr_data", int'(wr_data), 0);
        sb.delete();
        repeat (3) @(negedge clock);
        check("arst_hold_wr_en", int'(wr_en), 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("post_rst_busy", int'(busy), 0);

        // normal operation after reset
        fill_mem();
        run_cmd(1, 2, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
